// File: rtl/jtldtest_prog_arb.sv
// jtldtest_prog_arb: arbitrates a downloader (writes) and a verifier (reads) onto one SDRAM programming port.
// Optional ack/rdy watchdog is built in when JTLDTEST_TIMEOUT_EN is defined.
module jtldtest_prog_arb #(
   parameter int BURST = 8,
   parameter int TOUT  = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dl_req,
   input  logic [21:0] dl_addr,
   input  logic [15:0] dl_data,
   input  logic [1:0]  dl_mask,
   input  logic [1:0]  dl_ba,
   output logic        dl_done,
   input  logic        vr_req,
   input  logic [21:0] vr_addr,
   input  logic [1:0]  vr_ba,
   output logic        vr_done,
   output logic [15:0] vr_data,
   output logic [21:0] prog_addr,
   output logic [15:0] prog_data,
   output logic [1:0]  prog_mask,
   output logic [1:0]  prog_ba,
   output logic        prog_we,
   output logic        prog_rd,
   input  logic        prog_ack,
   input  logic        prog_rdy,
   input  logic [15:0] data_read,
   output logic        busy,
   output logic        tout_err
);

   localparam int BW = (BURST < 1) ? 1 : $clog2(BURST + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_RDY  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [21:0]   addr_q, addr_d;
   logic [15:0]   data_q, data_d;
   logic [1:0]    mask_q, mask_d;
   logic [1:0]    ba_q, ba_d;
   logic          we_q, we_d;
   logic          rd_q, rd_d;
   logic          dl_done_q, dl_done_d;
   logic          vr_done_q, vr_done_d;
   logic [15:0]   vr_data_q, vr_data_d;
   logic          busy_q, busy_d;
   logic          gnt_vr_q, gnt_vr_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          pick_vr_s;
   logic          tout_hit_s;

   // The verifier only wins once the downloader has used up its burst allowance.
   assign pick_vr_s = vr_req & (~dl_req | (bcnt_q == BW'(BURST)));

`ifdef JTLDTEST_TIMEOUT_EN
   logic [7:0] tcnt_q, tcnt_d;
   logic       tout_err_q, tout_err_d;

   assign tout_hit_s = (tcnt_q == 8'(TOUT - 1));
   assign tout_err   = tout_err_q;
`else
   assign tout_hit_s = 1'b0;
   assign tout_err   = 1'b0;
`endif

   // Next-state and output computation for the arbitration FSM.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      data_d    = data_q;
      mask_d    = mask_q;
      ba_d      = ba_q;
      we_d      = we_q;
      rd_d      = rd_q;
      gnt_vr_d  = gnt_vr_q;
      bcnt_d    = bcnt_q;
      vr_data_d = vr_data_q;
      dl_done_d = 1'b0;
      vr_done_d = 1'b0;
`ifdef JTLDTEST_TIMEOUT_EN
      tcnt_d     = 8'd0;
      tout_err_d = tout_err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (dl_req | vr_req) begin
               gnt_vr_d = pick_vr_s;
               state_d  = ST_ACK;
               if (pick_vr_s) begin
                  addr_d = vr_addr;
                  data_d = 16'h0000;
                  mask_d = 2'b00;
                  ba_d   = vr_ba;
                  we_d   = 1'b0;
                  rd_d   = 1'b1;
                  bcnt_d = {BW{1'b0}};
               end else begin
                  addr_d = dl_addr;
                  data_d = dl_data;
                  mask_d = dl_mask;
                  ba_d   = dl_ba;
                  we_d   = 1'b1;
                  rd_d   = 1'b0;
                  // Only grants that made the verifier wait count toward its turn.
                  bcnt_d = vr_req ? (bcnt_q + BW'(1)) : {BW{1'b0}};
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACK: begin
            if (prog_ack) begin
               we_d    = 1'b0;
               rd_d    = 1'b0;
               state_d = ST_RDY;
            end else if (tout_hit_s) begin
               we_d      = 1'b0;
               rd_d      = 1'b0;
               vr_data_d = gnt_vr_q ? 16'hDEAD : vr_data_q;
               dl_done_d = ~gnt_vr_q;
               vr_done_d = gnt_vr_q;
               state_d   = ST_DONE;
`ifdef JTLDTEST_TIMEOUT_EN
               tout_err_d = 1'b1;
`endif
            end else begin
               state_d = ST_ACK;
`ifdef JTLDTEST_TIMEOUT_EN
               tcnt_d = tcnt_q + 8'd1;
`endif
            end
         end
         ST_RDY: begin
            if (prog_rdy) begin
               vr_data_d = gnt_vr_q ? data_read : vr_data_q;
               dl_done_d = ~gnt_vr_q;
               vr_done_d = gnt_vr_q;
               state_d   = ST_DONE;
            end else if (tout_hit_s) begin
               we_d      = 1'b0;
               rd_d      = 1'b0;
               vr_data_d = gnt_vr_q ? 16'hDEAD : vr_data_q;
               dl_done_d = ~gnt_vr_q;
               vr_done_d = gnt_vr_q;
               state_d   = ST_DONE;
`ifdef JTLDTEST_TIMEOUT_EN
               tout_err_d = 1'b1;
`endif
            end else begin
               state_d = ST_RDY;
`ifdef JTLDTEST_TIMEOUT_EN
               tcnt_d = tcnt_q + 8'd1;
`endif
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= 22'd0;
         data_q    <= 16'd0;
         mask_q    <= 2'd0;
         ba_q      <= 2'd0;
         we_q      <= 1'b0;
         rd_q      <= 1'b0;
         dl_done_q <= 1'b0;
         vr_done_q <= 1'b0;
         vr_data_q <= 16'd0;
         busy_q    <= 1'b0;
         gnt_vr_q  <= 1'b0;
         bcnt_q    <= {BW{1'b0}};
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         mask_q    <= mask_d;
         ba_q      <= ba_d;
         we_q      <= we_d;
         rd_q      <= rd_d;
         dl_done_q <= dl_done_d;
         vr_done_q <= vr_done_d;
         vr_data_q <= vr_data_d;
         busy_q    <= busy_d;
         gnt_vr_q  <= gnt_vr_d;
         bcnt_q    <= bcnt_d;
      end
   end

`ifdef JTLDTEST_TIMEOUT_EN
   // Watchdog counter and sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt_q     <= 8'd0;
         tout_err_q <= 1'b0;
      end else begin
         tcnt_q     <= tcnt_d;
         tout_err_q <= tout_err_d;
      end
   end
`endif

   assign prog_addr = addr_q;
   assign prog_data = data_q;
   assign prog_mask = mask_q;
   assign prog_ba   = ba_q;
   assign prog_we   = we_q;
   assign prog_rd   = rd_q;
   assign dl_done   = dl_done_q;
   assign vr_done   = vr_done_q;
   assign vr_data   = vr_data_q;
   assign busy      = busy_q;

endmodule
